satcom_rx: RTL and testbench

- Receive-side counterpart of the satcom AFSK modulator (Bell-202 style, 1200 baud, mark 1200 Hz / space 2200 Hz).
- Takes signed ADC samples and demodulates tone by zero-crossing half-period measurement.
- Recovers async 8N1 framing, buffers bytes in a 4-deep FIFO and hands them to the UART transmitter chip via tdin/wrn/tbre.

---
 rtl/satcom_rx_pkg.sv | 12 +
 rtl/satcom_byte_fifo.sv | 42 ++++
 rtl/satcom_rx.sv | 211 +++++++++++++++++++++
 tb/tb_satcom_rx.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/satcom_rx_pkg.sv
// Shared satcom receive definitions: bit timing defaults common with the modulator and the
// framing / UART drain state encodings.
package satcom_rx_pkg;

  localparam int unsigned BitClksDefault    = 83333;
  localparam int unsigned HalfThreshDefault = 32197;

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} frame_state_e;

  typedef enum logic [1:0] {UIdle, UStrb, UHold} uart_state_e;

endpackage

// File: rtl/satcom_byte_fifo.sv
// Synchronous byte FIFO with first-word fall-through read data; push on a full FIFO is accepted
// only when a pop happens in the same cycle.
module satcom_byte_fifo #(
  parameter int unsigned Depth = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       push_i,
  input  logic [7:0] wdata_i,
  input  logic       pop_i,
  output logic [7:0] rdata_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int unsigned Aw = $clog2(Depth);

  logic [7:0]  mem_q [Depth];
  logic [Aw:0] wptr_q, rptr_q;
  logic        wr_en, rd_en;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[Aw] != rptr_q[Aw]) && (wptr_q[Aw-1:0] == rptr_q[Aw-1:0]);
  assign rd_en   = pop_i && !empty_o;
  assign wr_en   = push_i && (!full_o || pop_i);
  assign rdata_o = mem_q[rptr_q[Aw-1:0]];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (wr_en) wptr_q <= wptr_q + 1'b1;
      if (rd_en) rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wptr_q[Aw-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/satcom_rx.sv
// AFSK receiver: zero-crossing tone decision, 8N1 framing, byte FIFO and UART write-strobe drain.
// Build option SATCOM_RX_DEGLITCH_EN ignores sign changes arriving sooner than MIN_HALF clocks.
module satcom_rx
  import satcom_rx_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 100000000,
  parameter int unsigned BIT_CLKS    = BitClksDefault,
  parameter int unsigned HALF_THRESH = HalfThreshDefault,
  parameter int unsigned MIN_HALF    = 5000,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic        clk_100M,
  input  logic        rst,
  input  logic [15:0] adc_sample,
  input  logic        adc_valid,
  input  logic        tbre,
  output logic [7:0]  tdin,
  output logic        wrn,
  output logic        tone,
  output logic        frame_err,
  output logic        overflow
);

  localparam logic [15:0] HcntMax = 16'hFFFF;
  localparam logic [15:0] Thresh  = 16'(HALF_THRESH);
  localparam logic [16:0] HalfBit = 17'(BIT_CLKS / 2);
  localparam logic [16:0] BitLen  = 17'(BIT_CLKS);

  // Tone detector
  logic        sign_q;
  logic [15:0] hcnt_q;
  logic        tone_q, tone_prev_q;
  logic        sign_flip, crossing;
  logic        unused_adc_bits;

  assign unused_adc_bits = ^adc_sample[14:0];
  assign sign_flip       = adc_valid && (adc_sample[15] != sign_q);

`ifdef SATCOM_RX_DEGLITCH_EN
  assign crossing = sign_flip && (hcnt_q >= 16'(MIN_HALF));
`else
  assign crossing = sign_flip;
`endif

  always_ff @(posedge clk_100M or negedge rst) begin
    if (!rst) begin
      sign_q      <= 1'b0;
      hcnt_q      <= '0;
      tone_q      <= 1'b1;
      tone_prev_q <= 1'b1;
    end else begin
      tone_prev_q <= tone_q;
      if (crossing) begin
        sign_q <= adc_sample[15];
        hcnt_q <= '0;
        tone_q <= (hcnt_q >= Thresh);
      end else if (hcnt_q != HcntMax) begin
        hcnt_q <= hcnt_q + 16'd1;
      end else begin
        tone_q <= 1'b1;  // no crossings for a full count: treat line as idle mark
      end
    end
  end

  // Framing
  frame_state_e fstate_q, fstate_d;
  logic [16:0]  timer_q, timer_d;
  logic [2:0]   bit_idx_q, bit_idx_d;
  logic [7:0]   shreg_q, shreg_d;
  logic         frame_err_q, frame_err_d;
  logic         overflow_q, overflow_d;
  logic         expire, push;

  // FIFO / drain
  uart_state_e  ustate_q, ustate_d;
  logic [7:0]   tdin_q, tdin_d;
  logic         wrn_q, wrn_d;
  logic         hold_q, hold_d;
  logic         pop;
  logic [7:0]   fifo_rdata;
  logic         fifo_full, fifo_empty;

  assign expire = (timer_q == 17'd1);

  always_comb begin
    fstate_d    = fstate_q;
    timer_d     = timer_q;
    bit_idx_d   = bit_idx_q;
    shreg_d     = shreg_q;
    frame_err_d = 1'b0;
    push        = 1'b0;
    if (timer_q != '0) timer_d = timer_q - 17'd1;
    unique case (fstate_q)
      StIdle: begin
        if (tone_prev_q && !tone_q) begin
          timer_d  = HalfBit;
          fstate_d = StStart;
        end
      end
      StStart: begin
        if (expire) begin
          if (!tone_q) begin
            timer_d   = BitLen;
            bit_idx_d = '0;
            fstate_d  = StData;
          end else begin
            fstate_d = StIdle;
          end
        end
      end
      StData: begin
        if (expire) begin
          shreg_d   = {tone_q, shreg_q[7:1]};
          timer_d   = BitLen;
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) fstate_d = StStop;
        end
      end
      StStop: begin
        if (expire) begin
          if (tone_q) push = 1'b1;
          else        frame_err_d = 1'b1;
          fstate_d = StIdle;
        end
      end
      default: fstate_d = StIdle;
    endcase
  end

  assign overflow_d = overflow_q || (push && fifo_full && !pop);

  always_ff @(posedge clk_100M or negedge rst) begin
    if (!rst) begin
      fstate_q    <= StIdle;
      timer_q     <= '0;
      bit_idx_q   <= '0;
      shreg_q     <= '0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      fstate_q    <= fstate_d;
      timer_q     <= timer_d;
      bit_idx_q   <= bit_idx_d;
      shreg_q     <= shreg_d;
      frame_err_q <= frame_err_d;
      overflow_q  <= overflow_d;
    end
  end

  satcom_byte_fifo #(
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_100M),
    .rst_ni  (rst),
    .push_i  (push),
    .wdata_i (shreg_q),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    ustate_d = ustate_q;
    tdin_d   = tdin_q;
    wrn_d    = 1'b1;
    hold_d   = hold_q;
    pop      = 1'b0;
    unique case (ustate_q)
      UIdle: begin
        if (!fifo_empty && tbre) begin
          pop      = 1'b1;
          tdin_d   = fifo_rdata;
          wrn_d    = 1'b0;
          ustate_d = UStrb;
        end
      end
      UStrb: begin
        hold_d   = 1'b0;
        ustate_d = UHold;
      end
      UHold: begin
        // Two settle cycles, then wait for the UART to signal it took the byte
        if (!hold_q)     hold_d = 1'b1;
        else if (!tbre)  ustate_d = UIdle;
      end
      default: ustate_d = UIdle;
    endcase
  end

  always_ff @(posedge clk_100M or negedge rst) begin
    if (!rst) begin
      ustate_q <= UIdle;
      tdin_q   <= '0;
      wrn_q    <= 1'b1;
      hold_q   <= 1'b0;
    end else begin
      ustate_q <= ustate_d;
      tdin_q   <= tdin_d;
      wrn_q    <= wrn_d;
      hold_q   <= hold_d;
    end
  end

  assign tdin      = tdin_q;
  assign wrn       = wrn_q;
  assign tone      = tone_q;
  assign frame_err = frame_err_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_satcom_rx.sv
// Bench for satcom_rx: AFSK sine stimulus with scaled bit time, a queue scoreboard for UART
// writes and a simple UART model that drops tbre for a few cycles after each write strobe.
module tb_satcom_rx;

  localparam int unsigned BitClks = 120;  // scaled bit time
  localparam int unsigned Depth   = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] adc_sample;
  logic        adc_valid;
  logic        tbre;
  logic [7:0]  tdin;
  logic        wrn, tone, frame_err, overflow;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [7:0]  exp_q[$];
  int          exp_ferr = 0;
  int          ferr_cnt = 0;
  bit          exp_ovf  = 1'b0;
  bit          tbre_release = 1'b1;
  int          blocked_cnt = 0;
  int          busy = 0;
  logic        glitch_tone = 1'b1;

  always #5 clk = ~clk;

  satcom_rx #(
    .CLK_HZ      (144000),
    .BIT_CLKS    (BitClks),
    .HALF_THRESH (46),
    .MIN_HALF    (8),
    .FIFO_DEPTH  (Depth)
  ) dut (
    .clk_100M   (clk),
    .rst        (rst_n),
    .adc_sample (adc_sample),
    .adc_valid  (adc_valid),
    .tbre       (tbre),
    .tdin       (tdin),
    .wrn        (wrn),
    .tone       (tone),
    .frame_err  (frame_err),
    .overflow   (overflow)
  );

  task automatic check(input bit ok, input string name, input int act, input int exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic check_reset_values(input string tag);
    check(tdin == 8'h00,     {tag, "_tdin"},      tdin, 0);
    check(wrn == 1'b1,       {tag, "_wrn"},       wrn, 1);
    check(tone == 1'b1,      {tag, "_tone"},      tone, 1);
    check(frame_err == 1'b0, {tag, "_frame_err"}, frame_err, 0);
    check(overflow == 1'b0,  {tag, "_overflow"},  overflow, 0);
  endtask

  // Reference behaviour of one byte: framing error, drop on a full blocked FIFO, or delivery.
  task automatic model_accept(input logic [7:0] data, input bit stop_ok);
    if (!stop_ok) exp_ferr++;
    else if (!tbre_release && blocked_cnt >= Depth) exp_ovf = 1'b1;
    else begin
      exp_q.push_back(data);
      if (!tbre_release) blocked_cnt++;
    end
  endtask

  // Mark = one sine cycle per bit, space = two, so every bit starts at phase zero.
  task automatic send_bit(input bit b, input bit glitch, input bit do_rst);
    real amp, ph;
    int  s;
    amp = real'($urandom_range(3000, 30000));
    for (int n = 0; n < BitClks; n++) begin
      @(posedge clk); #1;
      ph = 3.14159265358979 * (b ? 2.0 : 4.0) * (real'(n) + 0.5) / real'(BitClks);
      s  = $rtoi(amp * $sin(ph));
      adc_sample = 16'(s);
      if (glitch && (n == 2 || n == 3)) adc_sample = 16'hFC18;
      if (glitch && n == 8) glitch_tone = tone;
      if (do_rst && n == 5) begin
        rst_n = 1'b0;
        #1;
        check_reset_values("mid_frame_reset");
        exp_ovf = 1'b0;
      end
      if (do_rst && n == 8) rst_n = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [7:0] data, input bit stop_ok, input int glitch_bit,
                            input int rst_bit);
    if (rst_bit < 0) model_accept(data, stop_ok);
    send_bit(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(data[i], i == glitch_bit, i == rst_bit);
    send_bit(stop_ok, 1'b0, 1'b0);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 8 && exp_q.size() != 0; i++) send_bit(1'b1, 1'b0, 1'b0);
    send_bit(1'b1, 1'b0, 1'b0);
    check(exp_q.size() == 0, "drain", exp_q.size(), 0);
  endtask

  // UART model
  initial begin
    tbre = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst_n)        busy = 0;
      else if (!wrn)     busy = $urandom_range(3, 8);
      else if (busy > 0) busy--;
      tbre = tbre_release && (busy == 0);
    end
  end

  // Scoreboard monitor
  initial begin
    logic [7:0] exp_b;
    logic       prev_wrn = 1'b1;
    int         since = 0;
    bit         have_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_wrn = 1'b1;
        continue;
      end
      if (!prev_wrn) check(wrn == 1'b1, "wrn_width", wrn, 1);
      if (!wrn) begin
        if (exp_q.size() == 0) begin
          check(1'b0, "unexpected_wrn", tdin, 0);
        end else begin
          exp_b = exp_q.pop_front();
          check(tdin == exp_b, "tdin", tdin, exp_b);
        end
        if (have_prev) check(since + 1 >= 4, "wrn_spacing", since + 1, 4);
        since     = 0;
        have_prev = 1'b1;
      end else begin
        since++;
      end
      if (frame_err) ferr_cnt++;
      prev_wrn = wrn;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] d;
    bit         ok;
    int         gap;
    rst_n      = 1'b0;
    adc_sample = 16'h0000;
    adc_valid  = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check_reset_values("reset");
    @(posedge clk); #1;
    rst_n     = 1'b1;
    adc_valid = 1'b1;
    repeat (2) send_bit(1'b1, 1'b0, 1'b0);

    // Single byte
    send_frame(8'h55, 1'b1, -1, -1);
    wait_drain();
    check(ferr_cnt == exp_ferr, "frame_err_single", ferr_cnt, exp_ferr);

    // Two bytes buffered behind a busy UART
    tbre_release = 1'b0;
    blocked_cnt  = 0;
    send_frame(8'hF0, 1'b1, -1, -1);
    send_frame(8'h55, 1'b1, -1, -1);
    tbre_release = 1'b1;
    wait_drain();
    check(overflow == exp_ovf, "overflow_two", overflow, exp_ovf);

    // Six bytes into a four-deep FIFO
    tbre_release = 1'b0;
    blocked_cnt  = 0;
    for (int i = 1; i <= 6; i++) send_frame(8'(i), 1'b1, -1, -1);
    check(overflow == exp_ovf, "overflow_six", overflow, exp_ovf);
    tbre_release = 1'b1;
    wait_drain();
    check(overflow == exp_ovf, "overflow_sticky", overflow, exp_ovf);

    // Stop bit sent as space
    send_frame(8'hA5, 1'b0, -1, -1);
    wait_drain();
    check(ferr_cnt == exp_ferr, "frame_err_stop", ferr_cnt, exp_ferr);

    // Short sign flip right after a real crossing inside a mark bit
    send_frame(8'hF3, 1'b1, 1, -1);
    wait_drain();
`ifdef SATCOM_RX_DEGLITCH_EN
    check(glitch_tone == 1'b1, "glitch_tone", glitch_tone, 1);
`else
    check(glitch_tone == 1'b0, "glitch_tone", glitch_tone, 0);
`endif

    // Reset during data bit 4, then a clean frame
    send_frame(8'hF6, 1'b1, -1, 4);
    repeat (2) send_bit(1'b1, 1'b0, 1'b0);
    check(overflow == exp_ovf, "overflow_after_reset", overflow, exp_ovf);
    send_frame(8'h3C, 1'b1, -1, -1);
    wait_drain();

    // Random bytes with occasional stop-bit errors
    for (int k = 0; k < 10; k++) begin
      d   = 8'($urandom);
      ok  = ($urandom_range(0, 4) != 0);
      send_frame(d, ok, -1, -1);
      gap = ok ? $urandom_range(0, 2) : $urandom_range(1, 2);
      repeat (gap) send_bit(1'b1, 1'b0, 1'b0);
    end
    wait_drain();
    check(ferr_cnt == exp_ferr, "frame_err_total", ferr_cnt, exp_ferr);
    check(overflow == exp_ovf, "overflow_final", overflow, exp_ovf);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
